// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped timer that sits on the CPU data-memory
// port beside the data SRAM. It uses SRAM-style signalling and returns read
// data one cycle after the access. It provides a prescaled 32-bit up-counter,
// a compare match, optional auto-reload and a level interrupt.
module mmio_timer_responder #(
    parameter logic [31:0] ID_VALUE     = 32'h544D_5231,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_CS,
    input  logic        i_OE,
    input  logic [3:0]  i_WEB,
    input  logic [13:0] i_A,
    input  logic [31:0] i_DI,
    output logic [31:0] o_DO,
    output logic        o_irq
);

    // Word offsets. Only A[2:0] are decoded, so every 8 words alias.
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4,
        REG_ID       = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_sel_t;

    // Architectural state. ctrl = {IRQ_EN, AUTO_RELOAD, EN}.
    logic [2:0]  ctrl;
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;

    // Next-state values
    logic [2:0]  ctrl_d;
    logic [15:0] prescale_d;
    logic [15:0] pcnt_d;
    logic [31:0] count_d;
    logic [31:0] compare_d;
    logic        match_d;

    // Access decode and datapath helpers
    reg_sel_t    sel;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wmask;
    logic        tick;
    logic        hit;
    logic [31:0] count_ticked;
    logic [31:0] count_base;
    logic [31:0] rdata;

    // The upper address bits only alias. They are gathered here so that it is
    // obvious they are ignored on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_A[13:3];

    // Replace the bytes selected by mask with new_val and keep the rest of old.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] mask,
                                                input logic [31:0] new_val);
        return (old & ~mask) | (new_val & mask);
    endfunction

    assign sel   = reg_sel_t'(i_A[2:0]);
    assign wr_en = i_CS && (i_WEB != 4'b1111);
    assign rd_en = i_CS && i_OE && (i_WEB == 4'b1111);
    assign wmask = {{8{~i_WEB[3]}}, {8{~i_WEB[2]}}, {8{~i_WEB[1]}}, {8{~i_WEB[0]}}};

    // A tick is a prescaler rollover. Compares use the pre-write COUNT and
    // COMPARE of this cycle.
    assign tick         = ctrl[0] && (pcnt == prescale);
    assign hit          = (count == compare);
    assign count_ticked = (hit && ctrl[1]) ? 32'd0 : count + 32'd1;
    assign count_base   = tick ? count_ticked : count;

    // Next-state logic: the tick result first, then CPU writes layered on top.
    // NOTE: every variable gets a default at the top of an always_comb; a path
    // that leaves one unassigned infers a latch.
    always_comb begin
        ctrl_d     = ctrl;
        prescale_d = prescale;
        compare_d  = compare;
        count_d    = count_base;
        match_d    = match;
        pcnt_d     = '0;
        if (ctrl[0]) begin
            pcnt_d = tick ? 16'd0 : pcnt + 16'd1;
        end

        if (wr_en) begin
            case (sel)
                REG_CTRL: begin
                    ctrl_d = i_WEB[0] ? ctrl : i_DI[2:0];
                    pcnt_d = '0;
                end
                REG_PRESCALE: begin
                    prescale_d = {i_WEB[1] ? prescale[15:8] : i_DI[15:8],
                                  i_WEB[0] ? prescale[7:0]  : i_DI[7:0]};
                    pcnt_d     = '0;
                end
                // The written bytes beat a tick. The other bytes keep the tick result.
                REG_COUNT:   count_d   = merge_lanes(count_base, wmask, i_DI);
                REG_COMPARE: compare_d = merge_lanes(compare, wmask, i_DI);
                REG_STATUS: begin
                    if (!i_WEB[0] && i_DI[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A match on this tick beats a W1C clear in the same cycle.
        if (tick && hit) begin
            match_d = 1'b1;
        end
    end

    // Read mux: register values as they stand before the current edge.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:     rdata = {29'd0, ctrl};
            REG_PRESCALE: rdata = {16'd0, prescale};
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = {31'd0, match};
            REG_ID:       rdata = ID_VALUE;
            default:      rdata = '0;
        endcase
    end

    // State registers and registered read data. Reset beats any access or tick.
    // NOTE: sequential state uses non-blocking assignments only. This way every
    // flop samples the values that stood before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            prescale <= PRESCALE_RST;
            pcnt     <= '0;
            count    <= '0;
            compare  <= 32'hFFFF_FFFF;
            match    <= 1'b0;
            o_DO     <= '0;
        end else begin
            ctrl     <= ctrl_d;
            prescale <= prescale_d;
            pcnt     <= pcnt_d;
            count    <= count_d;
            compare  <= compare_d;
            match    <= match_d;
            if (rd_en) begin
                o_DO <= rdata;
            end
        end
    end

    assign o_irq = match && ctrl[2];

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed testbench for mmio_timer_responder. Each bus access takes one
// cycle. Inputs are driven at the falling edge and outputs are sampled at the
// following falling edge.
module tb_mmio_timer_responder;

    logic        clk;
    logic        rst;
    logic        i_CS;
    logic        i_OE;
    logic [3:0]  i_WEB;
    logic [13:0] i_A;
    logic [31:0] i_DI;
    logic [31:0] o_DO;
    logic        o_irq;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [31:0] ID = 32'h544D_5231;

    logic [31:0] exp_rst [8];

    mmio_timer_responder dut (
        .clk   (clk),
        .rst   (rst),
        .i_CS  (i_CS),
        .i_OE  (i_OE),
        .i_WEB (i_WEB),
        .i_A   (i_A),
        .i_DI  (i_DI),
        .o_DO  (o_DO),
        .o_irq (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle access: drive now (at a falling edge), then return at the next
    // falling edge with the bus idle.
    task automatic bus(input logic [13:0] a, input logic [31:0] d,
                       input logic [3:0] web, input logic oe);
        i_CS  = 1'b1;
        i_OE  = oe;
        i_WEB = web;
        i_A   = a;
        i_DI  = d;
        @(negedge clk);
        i_CS  = 1'b0;
        i_OE  = 1'b0;
        i_WEB = 4'b1111;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        bus(a, d, 4'b0000, 1'b0);
    endtask

    task automatic rd_chk(input logic [13:0] a, input logic [31:0] exp, input string tag);
        bus(a, 32'h0, 4'b1111, 1'b1);
        check(tag, o_DO, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_rst = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, ID, 32'h0, 32'h0};
        rst   = 1'b1;
        i_CS  = 1'b0;
        i_OE  = 1'b0;
        i_WEB = 4'b1111;
        i_A   = '0;
        i_DI  = '0;

        // Reset state and read-back of every register
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_do", o_DO, 32'h0);
        check("reset_irq", {31'd0, o_irq}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd_chk(14'(i), exp_rst[i], $sformatf("reset_rd%0d", i));
            check($sformatf("reset_irq%0d", i), {31'd0, o_irq}, 32'd0);
        end

        // Byte-lane writes to COMPARE. WEB=1111 is a read, so the register
        // keeps its old value.
        bus(14'd3, 32'h1234_5678, 4'b1111, 1'b1);
        check("cmp_read_web1111", o_DO, 32'hFFFF_FFFF);
        wr(14'd3, 32'hAABB_CCDD);
        bus(14'd3, 32'h0000_1111, 4'b1100, 1'b0);
        rd_chk(14'd3, 32'hAABB_1111, "cmp_lanes");

        // Prescaled count: PRESCALE=3 gives one tick every 4 cycles, and the
        // match occurs when COUNT is 2.
        wr(14'd1, 32'd3);
        wr(14'd3, 32'd2);
        wr(14'd0, 32'h5);
        for (int k = 1; k <= 12; k++) begin
            rd_chk(14'd2, 32'((k - 1) / 4), $sformatf("pre_count_e%0d", k));
            check($sformatf("pre_irq_e%0d", k), {31'd0, o_irq}, {31'd0, k == 12});
        end
        rd_chk(14'd4, 32'd1, "pre_match");
        rd_chk(14'd2, 32'd3, "pre_count_after_match");
        wr(14'd4, 32'd1);
        check("w1c_irq_clear", {31'd0, o_irq}, 32'd0);
        rd_chk(14'd4, 32'd0, "w1c_status");
        wr(14'd0, 32'h0);

        // Auto-reload with PRESCALE=0: the sequence is 0,1,2,3,4,0,1.
        wr(14'd2, 32'd0);
        wr(14'd1, 32'd0);
        wr(14'd3, 32'd4);
        wr(14'd0, 32'h3);
        for (int k = 1; k <= 7; k++) begin
            rd_chk(14'd2, 32'((k - 1) % 5), $sformatf("reload_count%0d", k));
        end
        rd_chk(14'd4, 32'd1, "reload_match");
        check("reload_irq_masked", {31'd0, o_irq}, 32'd0);

        // A COUNT write on a tick cycle beats the tick.
        wr(14'd2, 32'd100);
        rd_chk(14'd2, 32'd100, "coll_count_write");
        rd_chk(14'd2, 32'd101, "coll_count_next");
        // A partial write: unwritten bytes take the tick result (0xFF -> 0x100).
        wr(14'd2, 32'h0000_00FF);
        bus(14'd2, 32'h0000_0011, 4'b1110, 1'b0);
        rd_chk(14'd2, 32'h0000_0111, "coll_count_lanes");

        // A match set beats a W1C clear in the same cycle.
        wr(14'd0, 32'h0);
        wr(14'd4, 32'd1);
        rd_chk(14'd4, 32'd0, "coll_pre_clear");
        wr(14'd2, 32'd4);
        wr(14'd0, 32'h3);
        wr(14'd4, 32'd1);
        rd_chk(14'd4, 32'd1, "coll_set_beats_clear");
        rd_chk(14'd2, 32'd1, "coll_reload_count");

        // Reset mid-count, with a write to COMPARE during the reset cycle
        wr(14'd0, 32'h0);
        wr(14'd3, 32'd1000);
        wr(14'd2, 32'd45);
        wr(14'd0, 32'h7);
        idle(5);
        rd_chk(14'd2, 32'd50, "mid_count50");
        check("mid_irq_before_rst", {31'd0, o_irq}, 32'd1);
        rst = 1'b1;
        wr(14'd3, 32'h0000_5555);
        rst = 1'b0;
        check("mid_rst_do", o_DO, 32'h0);
        check("mid_rst_irq", {31'd0, o_irq}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd_chk(14'(i), exp_rst[i], $sformatf("mid_rst_rd%0d", i));
        end
        idle(3);
        rd_chk(14'd2, 32'd0, "mid_rst_count_held");

        // Address aliasing, and writes that must be ignored
        rd_chk(14'h000D, ID, "alias_id");
        wr(14'd6, 32'hFFFF_FFFF);
        wr(14'd5, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_chk(14'(i), exp_rst[i], $sformatf("ignored_wr_rd%0d", i));
        end

        // COUNT wraps from all-ones to 0 without a match or flag.
        wr(14'd3, 32'h10);
        wr(14'd2, 32'hFFFF_FFFF);
        wr(14'd0, 32'h1);
        rd_chk(14'd2, 32'hFFFF_FFFF, "wrap_pre");
        rd_chk(14'd2, 32'h0, "wrap_zero");
        rd_chk(14'd4, 32'h0, "wrap_no_match");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
